servant_uart_mon: RTL and testbench
===================================

Name: servant_uart_mon

Overview:
Serial receive monitor on the servant GPIO/UART output `q`, instantiated next to the servant simulation top. Recovers 8N1 frames from the single-bit line and buffers the decoded bytes in a small FIFO. Presents them on a valid/ready stream for the bench console printer. Also flags framing errors and FIFO overruns for the self-checking bench.

Parameters:
clks_per_bit, 555, wb_clk cycles per UART bit (32 MHz / 57600); legal range 8..65535
depth, 4, FIFO entries; power of two, 2..64

Ports:
wb_clk  input  1  clock
wb_rst  input  1  reset; asynchronous, active-high
i_rx  input  1  serial line (servant `q`); asynchronous to wb_clk; idles high
o_data  output  8  byte at FIFO head
o_valid  output  1  FIFO non-empty
i_ready  input  1  consumer accepts o_data when o_valid & i_ready
o_level  output  clog2(depth)+1  current FIFO occupancy
o_frame_err  output  1  one-cycle pulse on bad stop bit
o_overrun  output  1  sticky; set when a good byte is dropped because the FIFO is full
i_clr  input  1  clears o_overrun (synchronous)
o_busy  output  1  high whenever the receive FSM is not in IDLE

Behaviour:
- Reset (async assert, sync-released by wb_clk): FSM=IDLE; synchronizer flops=1; FIFO empty.
- Reset values: o_valid=0, o_level=0, o_data=0, o_frame_err=0, o_overrun=0, o_busy=0.
- Reset mid-frame abandons the partial byte; nothing is pushed.
- Input sync: 2-flop synchronizer on i_rx. "rx" below means the synchronized value. Adds 2 cycles of fixed latency.
- Bit counter: 16-bit cnt, counts down; the sample point is when cnt==0.
- IDLE: a falling edge on rx (previous 1, current 0) loads cnt=clks_per_bit/2-1 and moves to START.
- START: at the sample point, rx==0 loads cnt=clks_per_bit-1 and bit index=0, then goes to DATA. rx==1 is a glitch: return to IDLE with no flags.
- DATA: at each sample point, shift rx into bit 7 of the shift register (LSB first) and reload cnt. After the 8th sample go to STOP.
- STOP, sample rx==1 (good frame):
  - Push the byte into the FIFO and return to IDLE in the same cycle, so a start edge in the next cycle is detected.
  - If the FIFO is full and no pop occurs that cycle: drop the byte and set o_overrun.
- STOP, sample rx==0 (bad frame): pulse o_frame_err for 1 cycle, push nothing, go to BREAK.
- BREAK: wait for rx==1, then go to IDLE. A held-low line produces exactly one o_frame_err.
- FIFO behaviour:
  - Circular buffer with write/read pointers one bit wider than the address.
  - Full is (wptr^rptr)=={1,0...}; empty is wptr==rptr.
  - Pop when o_valid & i_ready.
  - Push and pop in the same cycle are both honoured, including when full: the pop frees the slot, no overrun, o_level unchanged.
  - Pointers wrap modulo 2*depth.
  - o_data shows the head entry combinationally from the read pointer. It is stable while o_valid=1 and i_ready=0.
- Push latency: o_valid rises on the cycle after the stop-bit sample when the FIFO was empty.
- i_clr and a new overrun in the same cycle: set wins (o_overrun stays 1).
- i_ready while o_valid=0 is ignored.
- Bit timing: nominal sampling at mid-bit. Receiver tolerates ±3% baud error over a frame.

Test Plan:
- Clean byte: send 0x55 then 0xA3 at 555 clk/bit, i_ready=1 -> two o_valid beats with o_data 0x55 then 0xA3; o_frame_err=0; o_overrun=0.
- Glitch: drive i_rx low for 100 cycles in IDLE -> FSM returns to IDLE; no o_valid, no flags.
- Framing: send 0x3C with the stop bit held 0, then release the line high -> exactly one o_frame_err pulse; no push; the next frame 0x7E is received correctly.
- Overrun: i_ready=0, send 0x01..0x05 (depth 4) -> o_level=4, o_overrun=1. Then i_ready=1 drains 0x01,0x02,0x03,0x04 in order. i_clr -> o_overrun=0.
- Full with simultaneous pop: FIFO at 4, pulse i_ready exactly on the stop-sample cycle of 0x99 -> no overrun, o_level stays 4, 0x99 read last.
- Reset mid-frame: assert wb_rst during the DATA bits of 0xF0 -> all outputs at reset values immediately. After release, 0x0F is received correctly and no partial byte appears.

Source files
------------

// File: rtl/servant_uart_mon.sv
`default_nettype none
// ============================================================================
// Module      : servant_uart_mon
// Description : 8N1 serial receive monitor for the servant `q` output.
//               Recovers bytes from the line, queues them in a small FIFO
//               and presents them on a valid/ready stream. Flags framing
//               errors (stop bit low) and overruns (good byte dropped).
// Ports       : wb_clk, wb_rst   clock, async active-high reset
//               i_rx             serial line, idles high, asynchronous
//               o_data/o_valid   FIFO head byte / FIFO non-empty
//               i_ready          consumer accept (pop on o_valid & i_ready)
//               o_level          FIFO occupancy
//               o_frame_err      one-cycle pulse on a bad stop bit
//               o_overrun        sticky drop flag, cleared by i_clr
//               o_busy           receive FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module servant_uart_mon #(
   parameter int CLKS_PER_BIT = 555,
   parameter int DEPTH        = 4
) (
   input  logic                   wb_clk,
   input  logic                   wb_rst,
   input  logic                   i_rx,
   output logic [7:0]             o_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_frame_err,
   output logic                   o_overrun,
   input  logic                   i_clr,
   output logic                   o_busy
);

   localparam int          c_AW       = $clog2(DEPTH);
   localparam logic [15:0] c_CNT_FULL = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] c_CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronizer plus one history flop for falling-edge detect
   // ------------------------------------------------------------------
   logic r_sync1, r_sync2, r_rx_prev;
   logic w_rx, w_fall;

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1   <= i_rx;
         r_sync2   <= r_sync1;
         r_rx_prev <= r_sync2;
      end
   end

   assign w_rx   = r_sync2;
   assign w_fall = r_rx_prev & ~r_sync2;

   // ------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------
   state_t      r_state;
   logic [15:0] r_cnt;
   logic [2:0]  r_bit_idx;
   logic [7:0]  r_shift;
   logic        r_frame_err;
   logic        w_tick;

   assign w_tick = (r_cnt == 16'd0);

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 16'd0;
         r_bit_idx   <= 3'd0;
         r_shift     <= 8'h00;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         // Free-running down count; every sampling state reloads it.
         if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  // Half a bit puts the first sample in the middle of the start bit.
                  r_cnt   <= c_CNT_HALF;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_tick) begin
                  if (!w_rx) begin
                     r_cnt     <= c_CNT_FULL;
                     r_bit_idx <= 3'd0;
                     r_state   <= S_DATA;
                  end else begin
                     r_state <= S_IDLE;   // glitch, not a start bit
                  end
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  r_shift <= {w_rx, r_shift[7:1]};   // LSB arrives first
                  r_cnt   <= c_CNT_FULL;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end
            end
            S_STOP: begin
               if (w_tick) begin
                  if (w_rx) begin
                     // Push happens this cycle; back to IDLE at once so a
                     // start edge on the very next cycle is not missed.
                     r_state <= S_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               // Wait out a held-low line so it yields a single error.
               if (w_rx) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Byte FIFO: pointers carry one extra wrap bit to tell full from empty
   // ------------------------------------------------------------------
   logic [c_AW:0] r_wptr, r_rptr;
   logic [7:0]    r_mem [DEPTH];
   logic          r_overrun;
   logic          w_empty, w_full, w_pop, w_push_req, w_push, w_drop;

   assign w_empty    = (r_wptr == r_rptr);
   assign w_full     = ((r_wptr ^ r_rptr) == {1'b1, {c_AW{1'b0}}});
   assign w_pop      = ~w_empty & i_ready;
   assign w_push_req = (r_state == S_STOP) & w_tick & w_rx;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_drop     = w_push_req & w_full & ~w_pop;

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 8'h00;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= r_shift;
            r_wptr                  <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   // Sticky overrun; a new drop outranks a simultaneous clear.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (i_clr) begin
         r_overrun <= 1'b0;
      end
   end

   assign o_data      = r_mem[r_rptr[c_AW-1:0]];
   assign o_valid     = ~w_empty;
   assign o_level     = r_wptr - r_rptr;
   assign o_frame_err = r_frame_err;
   assign o_overrun   = r_overrun;
   assign o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_servant_uart_mon.sv
`default_nettype none
// ============================================================================
// Module      : tb_servant_uart_mon
// Description : Self-checking bench for servant_uart_mon. Serialises bytes
//               onto i_rx and compares the popped stream, occupancy and
//               flags against a queue-based model of the receiver.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servant_uart_mon;

   localparam int CLKS  = 24;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          wb_clk  = 1'b0;
   logic          wb_rst  = 1'b1;
   logic          i_rx    = 1'b1;
   logic          i_ready = 1'b0;
   logic          i_clr   = 1'b0;
   logic [7:0]    o_data;
   logic          o_valid;
   logic [LW-1:0] o_level;
   logic          o_frame_err;
   logic          o_overrun;
   logic          o_busy;

   int           n_checks   = 0;
   int           n_fail     = 0;
   int           ferr_cnt   = 0;
   byte unsigned model_q[$];
   bit           model_ovr  = 1'b0;
   bit           rand_ready = 1'b0;

   always #5 wb_clk = ~wb_clk;

   servant_uart_mon #(
      .CLKS_PER_BIT(CLKS),
      .DEPTH       (DEPTH)
   ) u_dut (
      .wb_clk     (wb_clk),
      .wb_rst     (wb_rst),
      .i_rx       (i_rx),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_level    (o_level),
      .o_frame_err(o_frame_err),
      .o_overrun  (o_overrun),
      .i_clr      (i_clr),
      .o_busy     (o_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge wb_clk);
      #1;
   endtask

   // Model of a completed good frame: queue it, or flag overrun when full.
   task automatic model_push(input byte unsigned b);
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else                        model_ovr = 1'b1;
   endtask

   // Serialise one 8N1 frame. stop_ok=0 holds the line low through the stop
   // bit and two more bit times before releasing it. pulse=1 raises i_ready
   // for exactly the cycle on which the stop bit is sampled.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit pulse);
      i_rx = 1'b0;
      tick(CLKS);
      for (int i = 0; i < 8; i++) begin
         i_rx = b[i];
         tick(CLKS);
      end
      i_rx = stop_ok;
      if (stop_ok && !pulse) model_push(b);
      if (pulse) begin
         // Sample edge: 2 sync + 1 edge-detect + half bit after stop starts.
         tick(CLKS / 2 + 2);
         i_ready = 1'b1;
         tick(1);
         i_ready = 1'b0;
         model_push(b);
         tick(CLKS - CLKS / 2 - 3);
      end else begin
         tick(CLKS);
      end
      if (!stop_ok) begin
         tick(2 * CLKS);
         chk("break_busy", o_busy, 1);
         i_rx = 1'b1;
         tick(CLKS);
      end
   endtask

   task automatic drain(input string tag);
      i_ready = 1'b1;
      for (int k = 0; k < 50 && o_valid; k++) tick(1);
      chk({tag, "_valid"}, o_valid, 0);
      chk({tag, "_model_empty"}, model_q.size(), 0);
   endtask

   // Consumer side: every handshake must hand over the model's head byte.
   always @(negedge wb_clk) begin
      if (!wb_rst) begin
         if (o_frame_err) ferr_cnt++;
         if (o_valid && i_ready) begin
            if (model_q.size() == 0) begin
               chk("pop_unexpected", 1, 0);
            end else begin
               chk("pop_data", o_data, model_q[0]);
               void'(model_q.pop_front());
            end
         end
      end
   end

   always @(posedge wb_clk) begin
      if (rand_ready) begin
         #1;
         i_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      logic [7:0] b;

      // Reset values
      tick(3);
      chk("rst_valid", o_valid, 0);
      chk("rst_level", o_level, 0);
      chk("rst_data", o_data, 0);
      chk("rst_ferr", o_frame_err, 0);
      chk("rst_ovr", o_overrun, 0);
      chk("rst_busy", o_busy, 0);
      wb_rst = 1'b0;
      tick(3);

      // Two clean bytes with a ready consumer
      i_ready = 1'b1;
      send_frame(8'h55, 1, 0);
      send_frame(8'hA3, 1, 0);
      tick(5);
      chk("clean_model_empty", model_q.size(), 0);
      chk("clean_valid", o_valid, 0);
      chk("clean_ferr_cnt", ferr_cnt, 0);
      chk("clean_ovr", o_overrun, 0);

      // Short low glitch: FSM leaves IDLE briefly then gives up silently
      i_rx = 1'b0;
      tick(CLKS / 4);
      i_rx = 1'b1;
      tick(4);
      chk("glitch_busy_start", o_busy, 1);
      tick(2 * CLKS);
      chk("glitch_busy_end", o_busy, 0);
      chk("glitch_valid", o_valid, 0);
      chk("glitch_ferr_cnt", ferr_cnt, 0);

      // Framing error followed by a good frame
      send_frame(8'h3C, 0, 0);
      chk("frame_ferr_cnt", ferr_cnt, 1);
      chk("frame_valid", o_valid, 0);
      chk("frame_busy", o_busy, 0);
      send_frame(8'h7E, 1, 0);
      tick(5);
      chk("frame_next_model_empty", model_q.size(), 0);

      // Overrun: five bytes into a four-entry FIFO with no consumer
      i_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 0);
      tick(2);
      chk("ovr_level", o_level, model_q.size());
      chk("ovr_level_full", o_level, DEPTH);
      chk("ovr_flag", o_overrun, model_ovr);
      drain("ovr_drain");
      chk("ovr_sticky", o_overrun, 1);
      i_clr = 1'b1;
      tick(1);
      i_clr = 1'b0;
      model_ovr = 1'b0;
      chk("ovr_clr", o_overrun, model_ovr);

      // Full FIFO with a pop on the exact stop-sample cycle
      i_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1, 0);
      chk("simul_pre_level", o_level, DEPTH);
      send_frame(8'h99, 1, 1);
      tick(2);
      chk("simul_level", o_level, DEPTH);
      chk("simul_ovr", o_overrun, model_ovr);
      chk("simul_ovr_zero", o_overrun, 0);
      drain("simul_drain");

      // Reset in the middle of a frame with a byte already queued
      i_ready = 1'b0;
      send_frame(8'($urandom_range(0, 255)), 1, 0);
      chk("mid_pre_valid", o_valid, 1);
      b = 8'hF0;
      i_rx = 1'b0;
      tick(CLKS);
      for (int i = 0; i < 3; i++) begin
         i_rx = b[i];
         tick(CLKS);
      end
      chk("mid_pre_busy", o_busy, 1);
      #2;
      wb_rst = 1'b1;
      i_rx   = 1'b1;
      #1;
      chk("mid_rst_valid", o_valid, 0);
      chk("mid_rst_level", o_level, 0);
      chk("mid_rst_data", o_data, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_ovr", o_overrun, 0);
      chk("mid_rst_ferr", o_frame_err, 0);
      model_q.delete();
      model_ovr = 1'b0;
      tick(2);
      wb_rst = 1'b0;
      tick(3);
      i_ready = 1'b1;
      send_frame(8'h0F, 1, 0);
      tick(5);
      chk("mid_after_model_empty", model_q.size(), 0);
      chk("mid_after_valid", o_valid, 0);

      // Random bytes with a randomly stalling consumer
      rand_ready = 1'b1;
      for (int i = 0; i < 8; i++) send_frame(8'($urandom_range(0, 255)), 1, 0);
      rand_ready = 1'b0;
      tick(2);
      drain("rand_drain");
      chk("rand_ovr", o_overrun, model_ovr);
      chk("final_ferr_cnt", ferr_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
